// File: rtl/fc_seq_pkg.sv
// Shared types and constants for the fully-connected layer frame sequencer.
// Holds the FSM state encoding and the completed-frame counter width.
package fc_seq_pkg;

    typedef enum logic [1:0] {
        FILL,
        FEED,
        WAIT,
        HOLD
    } fc_seq_state_t;

    localparam int FRAME_CNT_W = 16;

endpackage

// File: rtl/fc_layer_sequencer_if.sv
// Bundles the three data paths around the sequencer: upstream sample stream,
// layer burst/result pair and downstream result port.
// slave  : sequencer side (consumes s_*, drives fc_in_*, consumes fc_out_*, drives m_*)
// master : environment side (the opposite directions)
interface fc_layer_sequencer_if #(
    parameter int INPUT_W    = 16,
    parameter int OUTPUT_W   = 8,
    parameter int DIM_OUTPUT = 8
);

    logic [INPUT_W-1:0]                   s_dat;
    logic                                 s_valid;
    logic                                 s_ready;
    logic [INPUT_W-1:0]                   fc_in_dat;
    logic                                 fc_in_valid;
    logic [DIM_OUTPUT-1:0][OUTPUT_W-1:0]  fc_out_dat;
    logic                                 fc_out_valid;
    logic [DIM_OUTPUT-1:0][OUTPUT_W-1:0]  m_dat;
    logic                                 m_valid;
    logic                                 m_ready;

    modport slave (
        input  s_dat, s_valid,
        output s_ready,
        output fc_in_dat, fc_in_valid,
        input  fc_out_dat, fc_out_valid,
        output m_dat, m_valid,
        input  m_ready
    );

    modport master (
        output s_dat, s_valid,
        input  s_ready,
        input  fc_in_dat, fc_in_valid,
        output fc_out_dat, fc_out_valid,
        input  m_dat, m_valid,
        output m_ready
    );

endinterface

// File: rtl/fc_frame_buf.sv
// One-frame sample store: register array with a synchronous write port
// and an asynchronous read port.
// Ports: clk, we/waddr/wdat (write), raddr -> rdat (combinational read).
module fc_frame_buf #(
    parameter int DEPTH = 96,
    parameter int W     = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdat,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdat
);

    logic [W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdat;
        end
    end

    assign rdat = mem_q[raddr];

endmodule

// File: rtl/fc_layer_sequencer.sv
// Frame controller for one FC layer: buffers a frame, replays it as an unbroken
// burst, captures the layer result and hands it downstream, with a result timeout.
// Ports: clk, rst (sync, active high), bus (slave modport), frame_cnt, err_timeout.
module fc_layer_sequencer
    import fc_seq_pkg::*;
#(
    parameter int DIM_INPUT  = 96,
    parameter int DIM_OUTPUT = 8,
    parameter int INPUT_W    = 16,
    parameter int OUTPUT_W   = 8,
    parameter int TIMEOUT    = 256
) (
    input  logic                    clk,
    input  logic                    rst,
    fc_layer_sequencer_if.slave     bus,
    output logic [FRAME_CNT_W-1:0]  frame_cnt,
    output logic                    err_timeout
);

    localparam int AW = $clog2(DIM_INPUT);
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [AW-1:0] LAST_IDX = AW'(DIM_INPUT - 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);

    typedef logic [DIM_OUTPUT-1:0][OUTPUT_W-1:0] res_t;

    fc_seq_state_t          state_q, state_d;
    logic [AW-1:0]          wr_cnt_q, wr_cnt_d;
    logic [AW-1:0]          rd_cnt_q, rd_cnt_d;
    logic [TW-1:0]          to_cnt_q, to_cnt_d;
    logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic [INPUT_W-1:0]     fc_in_dat_q, fc_in_dat_d;
    logic                   fc_in_valid_q, fc_in_valid_d;
    res_t                   m_dat_q, m_dat_d;
    logic                   m_valid_q, m_valid_d;
    logic                   err_q, err_d;
    logic                   s_ready;
    logic                   wr_en;
    logic [INPUT_W-1:0]     rd_dat;

    // Upstream is only accepted while filling; no overlap with hold.
    assign s_ready = (state_q == FILL);
    assign wr_en   = s_ready && bus.s_valid;

    fc_frame_buf #(
        .DEPTH (DIM_INPUT),
        .W     (INPUT_W),
        .AW    (AW)
    ) u_buf (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wr_cnt_q),
        .wdat  (bus.s_dat),
        .raddr (rd_cnt_q),
        .rdat  (rd_dat)
    );

    always_comb begin
        state_d       = state_q;
        wr_cnt_d      = wr_cnt_q;
        rd_cnt_d      = rd_cnt_q;
        to_cnt_d      = to_cnt_q;
        frame_cnt_d   = frame_cnt_q;
        fc_in_dat_d   = fc_in_dat_q;
        fc_in_valid_d = 1'b0;
        m_dat_d       = m_dat_q;
        m_valid_d     = m_valid_q;
        err_d         = 1'b0;
        unique case (state_q)
            FILL: begin
                if (wr_en) begin
                    if (wr_cnt_q == LAST_IDX) begin
                        wr_cnt_d = '0;
                        state_d  = FEED;
                    end else begin
                        wr_cnt_d = wr_cnt_q + 1'b1;
                    end
                end
            end
            FEED: begin
                // Registered beat: visible the cycle after it is read.
                fc_in_dat_d   = rd_dat;
                fc_in_valid_d = 1'b1;
                if (rd_cnt_q == LAST_IDX) begin
                    rd_cnt_d = '0;
                    state_d  = WAIT;
                end else begin
                    rd_cnt_d = rd_cnt_q + 1'b1;
                end
            end
            WAIT: begin
                // A result arriving on the timeout cycle takes priority.
                if (bus.fc_out_valid) begin
                    m_dat_d   = bus.fc_out_dat;
                    m_valid_d = 1'b1;
                    to_cnt_d  = '0;
                    state_d   = HOLD;
                end else if (to_cnt_q == TO_LAST) begin
                    err_d    = 1'b1;
                    to_cnt_d = '0;
                    state_d  = FILL;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            HOLD: begin
                if (m_valid_q && bus.m_ready) begin
                    m_valid_d   = 1'b0;
                    frame_cnt_d = frame_cnt_q + 1'b1;
                    state_d     = FILL;
                end
            end
            default: begin
                state_d = FILL;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= FILL;
            wr_cnt_q      <= '0;
            rd_cnt_q      <= '0;
            to_cnt_q      <= '0;
            frame_cnt_q   <= '0;
            fc_in_dat_q   <= '0;
            fc_in_valid_q <= 1'b0;
            m_dat_q       <= '0;
            m_valid_q     <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_cnt_q      <= wr_cnt_d;
            rd_cnt_q      <= rd_cnt_d;
            to_cnt_q      <= to_cnt_d;
            frame_cnt_q   <= frame_cnt_d;
            fc_in_dat_q   <= fc_in_dat_d;
            fc_in_valid_q <= fc_in_valid_d;
            m_dat_q       <= m_dat_d;
            m_valid_q     <= m_valid_d;
            err_q         <= err_d;
        end
    end

    assign bus.s_ready     = s_ready;
    assign bus.fc_in_dat   = fc_in_dat_q;
    assign bus.fc_in_valid = fc_in_valid_q;
    assign bus.m_dat       = m_dat_q;
    assign bus.m_valid     = m_valid_q;
    assign frame_cnt       = frame_cnt_q;
    assign err_timeout     = err_q;

endmodule
